// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment driver with PWM, blanking and sign
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 100000,
  parameter int LZ_BLANK   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic                    upd_negative,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    frame_start,
  output logic                    sign_ovf
);

  localparam int PSW = $clog2(PRESCALE);
  localparam int DW  = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [PSW-1:0]          ps_cnt;
  logic [DW-1:0]           dig;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic                    shadow_neg;
  logic [4*NUM_DIGITS-1:0] active_digits;
  logic                    active_neg;

  logic                    ps_last;
  logic                    dig_last;
  logic                    boundary;
  logic                    transfer;

  logic [NUM_DIGITS:0]     zero_above;
  logic                    has_p;
  logic [DW-1:0]           sign_pos;
  logic [3:0]              cur_nib;
  logic                    cur_zero_above;
  logic [6:0]              glyph;
  logic [31:0]             on_limit;
  logic                    enable;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      4'd10:   seg_decode = 7'b1111110;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign ps_last   = (ps_cnt == PSW'(PRESCALE - 1));
  assign dig_last  = (dig == DW'(NUM_DIGITS - 1));
  assign boundary  = ps_last && dig_last;
  assign transfer  = upd_valid && !pending;
  assign upd_ready = !pending;

  // Slot prescaler and digit scan counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt <= '0;
      dig    <= '0;
    end else if (ps_last) begin
      ps_cnt <= '0;
      dig    <= dig_last ? '0 : dig + 1'b1;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Update capture into the shadow buffer; commit to the active buffer only at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= 1'b0;
      shadow_digits <= '0;
      shadow_neg    <= 1'b0;
      active_digits <= '0;
      active_neg    <= 1'b0;
    end else if (transfer) begin
      shadow_digits <= upd_digits;
      shadow_neg    <= upd_negative;
      pending       <= 1'b1;
    end else if (boundary && pending) begin
      active_digits <= shadow_digits;
      active_neg    <= shadow_neg;
      pending       <= 1'b0;
    end
  end

  // Zero-suffix map, minus-sign slot and glyph for the slot being scanned
  always_comb begin
    zero_above             = '0;
    zero_above[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (active_digits[i*4 +: 4] == 4'd0);
    end

    has_p    = 1'b0;
    sign_pos = '0;
    for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
      if (zero_above[j]) begin
        has_p    = 1'b1;
        sign_pos = DW'(j);
      end
    end

    cur_nib        = '0;
    cur_zero_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig == DW'(i)) begin
        cur_nib        = active_digits[i*4 +: 4];
        cur_zero_above = zero_above[i];
      end
    end

    if (active_neg && has_p && (dig == sign_pos)) begin
      glyph = SEG_MINUS;
    end else if ((LZ_BLANK != 0) && (dig != '0) && cur_zero_above) begin
      glyph = SEG_BLANK;
    end else begin
      glyph = seg_decode(cur_nib);
    end

    on_limit = (32'(brightness) + 32'd1) * 32'(PRESCALE / 16);
    enable   = (32'(ps_cnt) < on_limit) && !ps_last;
  end

  // Registered anode/cathode strobe, frame pulse and sign overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      anode       <= '1;
      cathode     <= SEG_BLANK;
      frame_start <= 1'b0;
      sign_ovf    <= 1'b0;
    end else begin
      anode       <= enable ? ~(NUM_DIGITS'(1) << dig) : '1;
      cathode     <= glyph;
      frame_start <= boundary;
      sign_ovf    <= active_neg && !has_p;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (4 digits, prescale 16)
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] MN = 7'b1111110;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] upd_digits;
  logic        upd_negative;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  brightness;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        frame_start;
  logic        sign_ovf;

  typedef struct packed {
    logic [3:0][6:0] cat;
    logic            ovf;
    logic [3:0]      bright;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic busy  = 1'b0;

  seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(16), .LZ_BLANK(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .upd_digits   (upd_digits),
    .upd_negative (upd_negative),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .brightness   (brightness),
    .anode        (anode),
    .cathode      (cathode),
    .frame_start  (frame_start),
    .sign_ovf     (sign_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] c3, input logic [6:0] c2, input logic [6:0] c1,
                              input logic [6:0] c0, input logic ovf, input logic [3:0] b);
    exp_t e;
    e.cat[3] = c3;
    e.cat[2] = c2;
    e.cat[1] = c1;
    e.cat[0] = c0;
    e.ovf    = ovf;
    e.bright = b;
    return e;
  endfunction

  // Checks the 64 cycles following a frame_start pulse against the queued frame
  task automatic check_frame();
    exp_t       e;
    int         slot;
    int         ps;
    logic [3:0] one;
    logic [3:0] exp_an;
    e    = q.pop_front();
    busy = 1'b1;
    one  = 4'b0001;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      slot   = k / 16;
      ps     = k % 16;
      exp_an = ((ps < int'(e.bright) + 1) && (ps != 15)) ? ~(one << slot) : 4'hF;
      chk($sformatf("slot%0d ps%0d cathode", slot, ps), 32'(cathode), 32'(e.cat[slot]));
      chk($sformatf("slot%0d ps%0d anode", slot, ps), 32'(anode), 32'(exp_an));
      chk($sformatf("slot%0d ps%0d sign_ovf", slot, ps), 32'(sign_ovf), 32'(e.ovf));
    end
    busy = 1'b0;
  endtask

  // Monitor: each frame_start with a queued expectation triggers a full-frame check
  initial begin
    forever begin
      @(negedge clk);
      while (frame_start && (q.size() > 0)) check_frame();
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || (q.size() > 0)) && (n < 3000));
    if (n >= 3000) chk("wait_idle timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [15:0] d, input logic neg);
    int n;
    upd_digits   = d;
    upd_negative = neg;
    upd_valid    = 1'b1;
    n = 0;
    while (!upd_ready && (n < 3000)) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("send ready timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " anode"}, 32'(anode), 32'h0000000F);
    chk({tag, " cathode"}, 32'(cathode), 32'h0000007F);
    chk({tag, " upd_ready"}, 32'(upd_ready), 32'd1);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, " sign_ovf"}, 32'(sign_ovf), 32'd0);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    upd_digits   = '0;
    upd_negative = 1'b0;
    upd_valid    = 1'b0;
    brightness   = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;

    // Negative 42, full brightness: minus floats to slot 2
    wait_idle();
    brightness = 4'd15;
    send(16'h0042, 1'b1);
    q.push_back(mk(BL, MN, G4, G2, 1'b0, 4'd15));

    // Same value at brightness 3: four lit cycles per slot
    wait_idle();
    brightness = 4'd3;
    send(16'h0042, 1'b1);
    q.push_back(mk(BL, MN, G4, G2, 1'b0, 4'd3));

    // Negative with every digit used: overflow, no minus
    wait_idle();
    brightness = 4'd15;
    send(16'h1234, 1'b1);
    q.push_back(mk(G1, G2, G3, G4, 1'b1, 4'd15));

    // Negative zero: minus in slot 1, digit 0 never blanked
    wait_idle();
    brightness = 4'd7;
    send(16'h0000, 1'b1);
    q.push_back(mk(BL, BL, MN, G0, 1'b0, 4'd7));

    // Back-to-back updates: second waits for the frame commit
    wait_idle();
    brightness = 4'd15;
    send(16'h0007, 1'b0);
    q.push_back(mk(BL, BL, BL, G7, 1'b0, 4'd15));
    chk("b2b ready low after transfer", 32'(upd_ready), 32'd0);
    upd_digits   = 16'h0A09;
    upd_negative = 1'b0;
    upd_valid    = 1'b1;
    n = 0;
    while (!upd_ready && (n < 200)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b2b ready wait bounded", 32'(n < 200), 32'd1);
    chk("b2b ready returns with frame_start", 32'(frame_start), 32'd1);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    q.push_back(mk(BL, MN, G0, G9, 1'b0, 4'd15));

    // Reset mid-frame with an update pending
    wait_idle();
    send(16'h0987, 1'b0);
    repeat (34) @(negedge clk);
    #1;
    chk("mid-frame pending", 32'(upd_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("mid reset");
    reset = 1'b0;
    q.push_back(mk(BL, BL, BL, G0, 1'b0, 4'd15));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && (n < 200));
    chk("frame_start delay after reset", 32'(n), 32'd64);

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
